ahb_arbiter: RTL
================

AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTER, default 4, number of bus masters (legal 2..16).
REQ-002 SHALL have parameter DEFAULT_MASTER, default 0, master granted when nobody requests.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports, in this order:
- HCLK  in  1  bus clock.
- HRESET  in  1  synchronous active-high reset.
- HBUSREQ  in  NUM_MASTER  per-master bus request.
- HLOCK  in  NUM_MASTER  per-master locked-transfer request.
- HGRANT  out  NUM_MASTER  one-hot grant.
- HMASTER  out  4  index of the address-phase owner.
- HMASTLOCK  out  1  current address phase is locked.
- HREADY  in  1  bus ready (transfer completes).
- HTRANS  in  2  muxed transfer type of the current owner.
- HBURST  in  3  muxed burst type of the current owner.

Function
REQ-005 SHALL keep HGRANT one-hot at all times; it is registered and changes only on a rising HCLK with HREADY=1.
REQ-006 SHALL update HMASTER to the index of HGRANT, and HMASTLOCK to HLOCK of that master, on each rising HCLK with HREADY=1; both hold while HREADY=0.
REQ-007 SHALL select round-robin: search starts at (last granted index + 1) mod NUM_MASTER; first master with HBUSREQ=1 wins.
REQ-008 SHALL grant DEFAULT_MASTER when no HBUSREQ bit is set and re-arbitration is permitted.
REQ-009 SHALL implement FSM states ARB, BURST and LOCK.
REQ-010 In ARB, re-arbitration SHALL be permitted every HREADY=1 cycle.
REQ-011 ARB->BURST SHALL occur when the owner issues HTRANS=NONSEQ with HREADY=1 and HBURST in {WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16}.
- On that transition, the beat counter loads (beats-1): 3, 7 or 15.
REQ-012 In BURST, each HTRANS=SEQ with HREADY=1 SHALL decrement the counter.
- HTRANS=BUSY SHALL hold the counter.
- Grant SHALL be frozen while the counter > 1.
REQ-013 When the counter reaches 1 with HREADY=1 (penultimate beat accepted), the FSM SHALL return to ARB so the new grant takes effect for the address phase after the last beat.
REQ-014 In BURST, HTRANS=IDLE or NONSEQ SHALL terminate the burst early: counter cleared, go to ARB (or reload if a new fixed-length NONSEQ).
REQ-015 HBURST=SINGLE or INCR SHALL NOT enter BURST; the grant may move on any HREADY=1 cycle.
REQ-016 ARB/BURST->LOCK SHALL occur when the granted master has HLOCK=1.
- In LOCK, grant SHALL stay with that master regardless of other requests.
- LOCK->ARB SHALL occur on the first HREADY=1 cycle with HLOCK of the owner = 0, after one further transfer.
REQ-017 The beat counter SHALL be 4 bits; it SHALL never wrap below 0.
REQ-018 Simultaneous request, drop and lock in one cycle SHALL resolve with priority LOCK > BURST > round-robin.
REQ-019 If the owner drops HBUSREQ in ARB, the grant SHALL move on the next HREADY=1 edge.

Reset
REQ-020 While HRESET=1, at the rising edge:
- HGRANT = one-hot(DEFAULT_MASTER); HMASTER = DEFAULT_MASTER; HMASTLOCK = 0.
- FSM = ARB; counter = 0; round-robin pointer = DEFAULT_MASTER.
REQ-021 Reset asserted mid-burst or mid-lock SHALL abandon the burst or lock immediately; no state is retained.

Structure
REQ-022 Shared package ahb_pkg SHALL hold:
- HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HBURST encodings (SINGLE=0..INCR16=7).
- FSM state type.
- A beats-per-burst function.
REQ-023 The round-robin picker SHALL be one combinational sub-module, ahb_rr_picker (inputs: request vector, pointer; output: one-hot winner).

Verification
REQ-024 Reset, no requests -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0.
REQ-025 HBUSREQ=4'b1010 held, single transfers, HREADY=1 -> grant alternates 4'b0010, 4'b1000, 4'b0010 on successive edges; HMASTER lags HGRANT by one cycle.
REQ-026 Master 2 runs INCR8; master 1 requests at beat 2; one HREADY=0 wait state inserted -> grant stays 4'b0100 until the 7th SEQ is accepted, then moves to 4'b0010.
REQ-027 Master 3 with HLOCK=1, HBUSREQ=4'b1111 for 10 cycles -> HGRANT=4'b1000 and HMASTMASTLOCK=1 throughout; grant releases one transfer after HLOCK drops.
REQ-028 INCR4 terminated by IDLE after 2 beats -> FSM returns to ARB; the next request is granted on the next HREADY=1 edge.
REQ-029 HRESET asserted during beat 5 of INCR16 -> next edge shows reset values (REQ-020); counter = 0.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB arbiter shared definitions
// Transfer/burst encodings, FSM state type, burst length helper
package ahb_pkg;

    localparam logic [1:0] HT_IDLE   = 2'd0;
    localparam logic [1:0] HT_BUSY   = 2'd1;
    localparam logic [1:0] HT_NONSEQ = 2'd2;
    localparam logic [1:0] HT_SEQ    = 2'd3;

    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR   = 3'd1;
    localparam logic [2:0] HB_WRAP4  = 3'd2;
    localparam logic [2:0] HB_INCR4  = 3'd3;
    localparam logic [2:0] HB_WRAP8  = 3'd4;
    localparam logic [2:0] HB_INCR8  = 3'd5;
    localparam logic [2:0] HB_WRAP16 = 3'd6;
    localparam logic [2:0] HB_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        ST_ARB,
        ST_BURST,
        ST_LOCK
    } arb_state_e;

    // Beats in a fixed-length burst; 0 for undefined-length types
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] n;
        case (hburst)
            HB_WRAP4, HB_INCR4:   n = 5'd4;
            HB_WRAP8, HB_INCR8:   n = 5'd8;
            HB_WRAP16, HB_INCR16: n = 5'd16;
            default:              n = 5'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Round-robin request picker
// Searches from ptr+1 upward (wrapping) and returns the first requester
module ahb_rr_picker #(
    parameter int NUM_MASTER = 4
) (
    input  logic [NUM_MASTER-1:0] req,
    input  logic [3:0]            ptr,
    output logic [NUM_MASTER-1:0] gnt
);

    int   idx;
    logic found;

    // First requester after the pointer wins
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_MASTER; i++) begin
            idx = (int'(ptr) + i) % NUM_MASTER;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter
// Round-robin grant with fixed-burst hold and locked-transfer hold
module ahb_arbiter #(
    parameter int NUM_MASTER     = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [NUM_MASTER-1:0] HBUSREQ,
    input  logic [NUM_MASTER-1:0] HLOCK,
    output logic [NUM_MASTER-1:0] HGRANT,
    output logic [3:0]            HMASTER,
    output logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST
);

    import ahb_pkg::*;

    localparam logic [3:0] DEF_IDX = 4'(DEFAULT_MASTER);
    localparam logic [NUM_MASTER-1:0] DEF_GNT =
        NUM_MASTER'(1) << DEFAULT_MASTER;

    arb_state_e            state_q, state_d;
    logic [NUM_MASTER-1:0] grant_q, grant_d;
    logic [3:0]            master_q, master_d;
    logic                  mastlock_q, mastlock_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            ptr_q, ptr_d;

    logic [NUM_MASTER-1:0] pick;
    logic [NUM_MASTER-1:0] rr_gnt;
    logic [3:0]            rr_idx;
    logic [3:0]            gidx;
    logic                  owner_lock;
    logic                  owner_kept;
    logic [4:0]            beats;
    logic                  fixed;
    logic [3:0]            load;
    logic                  rearb;

    ahb_rr_picker #(
        .NUM_MASTER(NUM_MASTER)
    ) u_pick (
        .req(HBUSREQ),
        .ptr(ptr_q),
        .gnt(pick)
    );

    // Index encoders, fall back to the default master when idle
    always_comb begin
        gidx   = '0;
        rr_idx = DEF_IDX;
        rr_gnt = DEF_GNT;
        for (int i = 0; i < NUM_MASTER; i++) begin
            if (grant_q[i]) gidx = 4'(i);
        end
        if (pick != '0) begin
            rr_gnt = pick;
            for (int i = 0; i < NUM_MASTER; i++) begin
                if (pick[i]) rr_idx = 4'(i);
            end
        end
    end

    assign owner_lock = |(HLOCK & grant_q);
    assign owner_kept = (gidx == master_q);
    assign beats      = burst_beats(HBURST);
    assign fixed      = (beats != 5'd0);
    assign load       = 4'(beats - 5'd1);

    // Next state: LOCK beats BURST beats round-robin
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        master_d   = master_q;
        mastlock_d = mastlock_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        rearb      = 1'b0;
        if (HREADY) begin
            master_d   = gidx;
            mastlock_d = owner_lock;
            unique case (state_q)
                ST_ARB: begin
                    if (owner_lock) begin
                        state_d = ST_LOCK;
                        cnt_d   = '0;
                    end else if (HTRANS == HT_NONSEQ && fixed
                                 && owner_kept) begin
                        state_d = ST_BURST;
                        cnt_d   = load;
                    end else begin
                        rearb = 1'b1;
                        if (HTRANS == HT_SEQ && cnt_q != '0)
                            cnt_d = cnt_q - 4'd1;
                        else
                            cnt_d = '0;
                    end
                end
                ST_BURST: begin
                    if (owner_lock) begin
                        state_d = ST_LOCK;
                        cnt_d   = '0;
                    end else begin
                        unique case (HTRANS)
                            HT_SEQ: begin
                                if (cnt_q > 4'd1) begin
                                    cnt_d = cnt_q - 4'd1;
                                    if (cnt_q <= 4'd2)
                                        state_d = ST_ARB;
                                end else begin
                                    cnt_d   = '0;
                                    state_d = ST_ARB;
                                    rearb   = 1'b1;
                                end
                            end
                            HT_BUSY: begin
                                cnt_d = cnt_q;
                            end
                            HT_NONSEQ: begin
                                if (fixed) begin
                                    cnt_d = load;
                                end else begin
                                    cnt_d   = '0;
                                    state_d = ST_ARB;
                                    rearb   = 1'b1;
                                end
                            end
                            HT_IDLE: begin
                                cnt_d   = '0;
                                state_d = ST_ARB;
                                rearb   = 1'b1;
                            end
                        endcase
                    end
                end
                ST_LOCK: begin
                    if (!owner_lock) state_d = ST_ARB;
                end
                default: begin
                    state_d = ST_ARB;
                    cnt_d   = '0;
                end
            endcase
            if (rearb) begin
                grant_d = rr_gnt;
                ptr_d   = rr_idx;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_ARB;
            grant_q    <= DEF_GNT;
            master_q   <= DEF_IDX;
            mastlock_q <= 1'b0;
            cnt_q      <= '0;
            ptr_q      <= DEF_IDX;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTLOCK = mastlock_q;

endmodule
